// File: rtl/agu_pkg.sv
// Shared definitions for the AGU stage sequencer: FSM state encoding,
// default geometry and the popcount helper used by the bank mapper.
package agu_pkg;

  localparam int AGU_LANES   = 16;
  localparam int AGU_D_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_K1 = 2'd1,
    ST_RUN_K2 = 2'd2,
    ST_DONE   = 2'd3
  } agu_state_e;

  // Population count of a 32-bit word (result 0..32).
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/agu_bank_map.sv
// Bank mapper for one lane: ma = (offset + popcount(addr)) mod LANES,
// zero-extended to D_WIDTH.
module agu_bank_map
  import agu_pkg::*;
#(
  parameter int  LANES   = AGU_LANES,
  parameter int  D_WIDTH = AGU_D_WIDTH,
  localparam int LB      = $clog2(LANES)
) (
  input  logic [LB-1:0]      offset,
  input  logic [D_WIDTH-1:0] addr,
  output logic [D_WIDTH-1:0] ma
);

  logic [5:0] pc_s;
  logic [5:0] sum_s;

  // Offset plus popcount stays below 64, so a 6-bit sum never overflows.
  always_comb begin
    pc_s  = popcount32(32'(addr));
    sum_s = {{(6-LB){1'b0}}, offset} + pc_s;
    ma    = D_WIDTH'(sum_s % 6'(LANES));
  end

endmodule

// File: rtl/agu_stage_sequencer.sv
// Sequences radix-LANES (k1) stages and an optional radix-2 (k2) stage,
// emitting per-lane bank/address indices with a valid/ready handshake.
module agu_stage_sequencer
  import agu_pkg::*;
#(
  parameter int LANES         = 16,
  parameter int D_WIDTH       = 10,
  parameter int GROUPS        = 64,
  parameter int NUM_K1_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          k2_en,
  output logic                          ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][D_WIDTH-1:0] MA_idx,
  output logic [LANES-1:0][D_WIDTH-1:0] BN_idx,
  output logic                          last_stage,
  output logic [D_WIDTH-1:0]            stage_out,
  output logic                          done
);

  localparam int LB    = $clog2(LANES);
  localparam int GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PAIRS = GROUPS * LANES / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  agu_state_e         state_r, next_state_s;
  logic [GW-1:0]      group_r, group_s;
  logic [D_WIDTH-1:0] stage_r, stage_s;
  logic [PW-1:0]      pair_r, pair_s;
  logic               k2_r, k2_s;
  logic               fire_s;

  assign fire_s = out_valid && out_ready;

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      group_r <= '0;
      stage_r <= '0;
      pair_r  <= '0;
      k2_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      group_r <= group_s;
      stage_r <= stage_s;
      pair_r  <= pair_s;
      k2_r    <= k2_s;
    end
  end

  // Next-state and counter advance; counters move only on an accepted beat.
  always_comb begin
    next_state_s = state_r;
    group_s      = group_r;
    stage_s      = stage_r;
    pair_s       = pair_r;
    k2_s         = k2_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_RUN_K1;
          group_s      = '0;
          stage_s      = '0;
          pair_s       = '0;
          k2_s         = k2_en;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN_K1: begin
        if (!fire_s) begin
          next_state_s = ST_RUN_K1;
        end else if (group_r != GW'(GROUPS - 1)) begin
          group_s = group_r + GW'(1);
        end else begin
          group_s = '0;
          if (stage_r != D_WIDTH'(NUM_K1_STAGES - 1)) begin
            stage_s = stage_r + D_WIDTH'(1);
          end else if (k2_r) begin
            next_state_s = ST_RUN_K2;
            stage_s      = D_WIDTH'(NUM_K1_STAGES);
            pair_s       = '0;
          end else begin
            next_state_s = ST_DONE;
          end
        end
      end
      ST_RUN_K2: begin
        if (!fire_s) begin
          next_state_s = ST_RUN_K2;
        end else if (pair_r != PW'(PAIRS - 1)) begin
          pair_s = pair_r + PW'(1);
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  logic [D_WIDTH-1:0]            e0_s, e1_s, bn0_s, bn1_s;
  logic [LANES-1:0][LB-1:0]      lane_off_s;
  logic [LANES-1:0][D_WIDTH-1:0] lane_addr_s;
  logic [LANES-1:0][D_WIDTH-1:0] lane_ma_s;
  logic [LANES-1:0]              lane_en_s;
  logic [LANES-1:0][D_WIDTH-1:0] ma_nx_s;
  logic [LANES-1:0][D_WIDTH-1:0] bn_nx_s;
  logic                          valid_nx_s, ready_nx_s, done_nx_s, last_nx_s;
  logic [D_WIDTH-1:0]            stage_nx_s;

  // Lane operands for the beat that will be presented after this edge.
  always_comb begin
    e0_s        = D_WIDTH'({pair_s, 1'b0});
    e1_s        = D_WIDTH'({pair_s, 1'b1});
    bn0_s       = e0_s >> LB;
    bn1_s       = e1_s >> LB;
    lane_off_s  = '0;
    lane_addr_s = '0;
    lane_en_s   = '0;
    case (next_state_s)
      ST_RUN_K1: begin
        for (int j = 0; j < LANES; j++) begin
          lane_off_s[j]  = LB'(j);
          lane_addr_s[j] = D_WIDTH'(group_s);
          lane_en_s[j]   = 1'b1;
        end
      end
      ST_RUN_K2: begin
        lane_off_s[0]  = e0_s[LB-1:0];
        lane_addr_s[0] = bn0_s;
        lane_en_s[0]   = 1'b1;
        lane_off_s[1]  = e1_s[LB-1:0];
        lane_addr_s[1] = bn1_s;
        lane_en_s[1]   = 1'b1;
      end
      default: begin
        lane_en_s = '0;
      end
    endcase
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    agu_bank_map #(
      .LANES   (LANES),
      .D_WIDTH (D_WIDTH)
    ) u_bank_map (
      .offset (lane_off_s[j]),
      .addr   (lane_addr_s[j]),
      .ma     (lane_ma_s[j])
    );
    assign ma_nx_s[j] = lane_en_s[j] ? lane_ma_s[j]   : '0;
    assign bn_nx_s[j] = lane_en_s[j] ? lane_addr_s[j] : '0;
  end

  // Status outputs derived from the upcoming state.
  always_comb begin
    valid_nx_s = (next_state_s == ST_RUN_K1) || (next_state_s == ST_RUN_K2);
    ready_nx_s = (next_state_s == ST_IDLE);
    done_nx_s  = (next_state_s == ST_DONE);
    last_nx_s  = (next_state_s == ST_RUN_K2);
    if (valid_nx_s) begin
      stage_nx_s = stage_s;
    end else begin
      stage_nx_s = '0;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b1;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      last_stage <= 1'b0;
      stage_out  <= '0;
      MA_idx     <= '0;
      BN_idx     <= '0;
    end else begin
      ready      <= ready_nx_s;
      out_valid  <= valid_nx_s;
      done       <= done_nx_s;
      last_stage <= last_nx_s;
      stage_out  <= stage_nx_s;
      MA_idx     <= ma_nx_s;
      BN_idx     <= bn_nx_s;
    end
  end

endmodule

// File: tb/tb_agu_stage_sequencer.sv
// Directed bench for agu_stage_sequencer with LANES=4, GROUPS=4, NUM_K1_STAGES=2.
module tb_agu_stage_sequencer;

  localparam int LANES = 4;
  localparam int DW    = 10;
  localparam int GROUPS = 4;
  localparam int NK1   = 2;

  logic               clk = 1'b0;
  logic               rst, start, k2_en, out_ready;
  logic               ready, out_valid, last_stage, done;
  logic [LANES-1:0][DW-1:0] MA_idx, BN_idx;
  logic [DW-1:0]      stage_out;

  int total = 0;
  int bad   = 0;

  agu_stage_sequencer #(
    .LANES(LANES), .D_WIDTH(DW), .GROUPS(GROUPS), .NUM_K1_STAGES(NK1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k2_en(k2_en), .ready(ready),
    .out_valid(out_valid), .out_ready(out_ready), .MA_idx(MA_idx), .BN_idx(BN_idx),
    .last_stage(last_stage), .stage_out(stage_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pc(input int v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic logic [63:0] k1_ma(input int g);
    logic [63:0] v = '0;
    for (int j = 0; j < LANES; j++) v[j*DW +: DW] = DW'((j + pc(g)) % LANES);
    return v;
  endfunction

  function automatic logic [63:0] k1_bn(input int g);
    logic [63:0] v = '0;
    for (int j = 0; j < LANES; j++) v[j*DW +: DW] = DW'(g);
    return v;
  endfunction

  function automatic logic [63:0] k2_vec(input int p, input bit want_ma);
    logic [63:0] v = '0;
    for (int k = 0; k < 2; k++) begin
      int e  = 2 * p + k;
      int bn = e / LANES;
      v[k*DW +: DW] = want_ma ? DW'(((e % LANES) + pc(bn)) % LANES) : DW'(bn);
    end
    return v;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_last"}, 64'(last_stage), 64'd0);
    chk({tag, "_stage"}, 64'(stage_out), 64'd0);
    chk({tag, "_ma"}, 64'(MA_idx), 64'd0);
    chk({tag, "_bn"}, 64'(BN_idx), 64'd0);
  endtask

  // Beat b of a run: first NK1*GROUPS are k1 beats, then k2 pairs.
  task automatic check_beat(input string tag, input int b);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    if (b < NK1 * GROUPS) begin
      chk({tag, "_last"}, 64'(last_stage), 64'd0);
      chk({tag, "_stage"}, 64'(stage_out), 64'(b / GROUPS));
      chk({tag, "_ma"}, 64'(MA_idx), k1_ma(b % GROUPS));
      chk({tag, "_bn"}, 64'(BN_idx), k1_bn(b % GROUPS));
    end else begin
      chk({tag, "_last"}, 64'(last_stage), 64'd1);
      chk({tag, "_stage"}, 64'(stage_out), 64'(NK1));
      chk({tag, "_ma"}, 64'(MA_idx), k2_vec(b - NK1 * GROUPS, 1'b1));
      chk({tag, "_bn"}, 64'(BN_idx), k2_vec(b - NK1 * GROUPS, 1'b0));
    end
  endtask

  // Full run; optional 3-cycle stall with a stray start at beat stall_at.
  task automatic run_full(input string tag, input bit k2, input int stall_at);
    int nbeats = NK1 * GROUPS + (k2 ? GROUPS * LANES / 2 : 0);
    start = 1'b1; k2_en = k2; out_ready = 1'b1;
    tick();
    start = 1'b0; k2_en = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      check_beat(tag, b);
      if (b == 3) begin
        chk({tag, "_g3_ma"}, 64'(MA_idx), 64'({10'd1, 10'd0, 10'd3, 10'd2}));
        chk({tag, "_g3_bn"}, 64'(BN_idx), 64'({10'd3, 10'd3, 10'd3, 10'd3}));
      end
      if (k2 && b == 13) begin
        chk({tag, "_p5_ma"}, 64'(MA_idx), 64'({10'd0, 10'd0, 10'd0, 10'd3}));
        chk({tag, "_p5_bn"}, 64'(BN_idx), 64'({10'd0, 10'd0, 10'd2, 10'd2}));
        chk({tag, "_p5_stage"}, 64'(stage_out), 64'd2);
      end
      if (b == stall_at) begin
        out_ready = 1'b0; start = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_beat({tag, "_stall"}, b);
        end
        out_ready = 1'b1; start = 1'b0;
      end
      tick();
    end
    chk({tag, "_done_pulse"}, 64'(done), 64'd1);
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(ready), 64'd0);
    start = 1'b1; k2_en = 1'b1;
    tick();
    start = 1'b0; k2_en = 1'b0;
    check_idle({tag, "_after_done"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k2_en = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    run_full("k2run", 1'b1, -1);
    run_full("k1only", 1'b0, -1);
    run_full("stall", 1'b1, 2);

    // Reset at beat 5 aborts the run without a done pulse.
    start = 1'b1; k2_en = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; k2_en = 1'b0;
    for (int b = 0; b < 5; b++) begin
      check_beat("pre_rst", b);
      tick();
    end
    check_beat("beat5", 5);
    rst = 1'b1;
    tick();
    check_idle("mid_rst");
    start = 1'b1;
    tick();
    check_idle("rst_prio");
    rst = 1'b0; start = 1'b0;
    tick();
    check_idle("post_rst");
    run_full("replay", 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agu_stage_sequencer.md
AGU_STAGE_SEQUENCER -- requirements
Module: agu_stage_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 16, number of bank lanes; power of two, 2 to 16.
REQ-002 SHALL have parameter D_WIDTH, default 10, width of each index.
REQ-003 SHALL have parameter GROUPS, default 64, groups per radix-LANES (k1) stage; power of two.
REQ-004 SHALL have parameter NUM_K1_STAGES, default 2, number of k1 stages per run (at least 1).
REQ-005 clk  input  1  clock; one clock domain; reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  run request; accepted only in IDLE.
REQ-008 k2_en  input  1  append the radix-2 last stage; sampled when start is accepted.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 out_valid  output  1  index beat valid.
REQ-011 out_ready  input  1  consumer accepts the beat.
REQ-012 MA_idx  output  LANES x D_WIDTH  memory-bank index per lane.
REQ-013 BN_idx  output  LANES x D_WIDTH  bank-address index per lane.
REQ-014 last_stage  output  1  current beat belongs to the k2 stage.
REQ-015 stage_out  output  D_WIDTH  current stage number, zero-based.
REQ-016 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-017 SHALL implement the states IDLE, RUN_K1, RUN_K2 and DONE.
REQ-018 IDLE->RUN_K1 SHALL occur on start; start outside IDLE SHALL be ignored.
REQ-019 The first beat SHALL be valid in the cycle after start is accepted, so latency is 1.
REQ-020 Counters SHALL advance only on out_valid&&out_ready; outputs SHALL hold while out_valid&&!out_ready.
REQ-021 A RUN_K1 beat for group g SHALL drive, for every lane j: BN_idx[j]=g and MA_idx[j]=(j+popcount(g)) mod LANES.
REQ-022 The k1 group counter SHALL count 0..GROUPS-1, then wrap to 0 and increment stage_out.
REQ-023 After stage NUM_K1_STAGES-1 wraps, the block SHALL enter RUN_K2 if the latched k2_en=1, otherwise DONE.
REQ-024 A RUN_K2 beat for pair p (0..GROUPS*LANES/2-1) SHALL use elements e0=2p and e1=2p+1.
REQ-025 For each RUN_K2 element e: BN=e>>log2(LANES) and MA=((e mod LANES)+popcount(BN)) mod LANES.
REQ-026 RUN_K2 beats SHALL drive the e0 indices on lane 0 and the e1 indices on lane 1; lanes 2..LANES-1 SHALL be 0.
REQ-027 last_stage SHALL be 1 only in RUN_K2; during RUN_K2, stage_out SHALL equal NUM_K1_STAGES.
REQ-028 Acceptance of the last pair SHALL move the block to DONE.
REQ-029 DONE SHALL last exactly 1 cycle with done=1 and out_valid=0, then return to IDLE.
REQ-030 A start asserted during DONE SHALL be ignored.
REQ-031 Indices SHALL be zero-extended to D_WIDTH; modulo SHALL be taken on the low log2(LANES) bits.
REQ-032 All outputs SHALL be registered; outside RUN states out_valid=0 and all index outputs SHALL be 0.

Reset
REQ-033 rst SHALL force IDLE, ready=1, out_valid=0, done=0, last_stage=0, stage_out=0, all MA_idx/BN_idx=0, all counters=0 and latched k2_en=0.
REQ-034 rst asserted mid-run SHALL abort the run on the next edge without a done pulse; rst SHALL have priority over start.

Structure
REQ-035 Shared package agu_pkg SHALL hold the state enum typedef and the default LANES/D_WIDTH constants.
REQ-036 A combinational sub-module agu_bank_map SHALL compute (offset+popcount(addr)) mod LANES and be instantiated once per output lane.

Verification (LANES=4, GROUPS=4, NUM_K1_STAGES=2)
REQ-037 start, k2_en=1, out_ready=1 -> 16 consecutive beats, done 1 cycle after the 16th, then ready=1.
REQ-038 k1 stage 0, g=3 -> BN_idx={3,3,3,3}, MA_idx={2,3,0,1}, last_stage=0.
REQ-039 k2 pair p=5 -> MA_idx[0]=3, BN_idx[0]=2, MA_idx[1]=0, BN_idx[1]=2, lanes 2-3 zero, stage_out=2.
REQ-040 k2_en=0 -> 8 beats, no last_stage, done after beat 8.
REQ-041 out_ready held 0 for 3 cycles mid-stage -> beat held stable and no beat lost or repeated; a start pulse while busy has no effect.
REQ-042 rst at beat 5 -> next cycle IDLE with all outputs zero and no done; a fresh start replays from g=0.
